// File: rtl/axil_rdata_channel.sv
// axil_rdata_channel: AXI4-Lite R stage, one backend read per address edge, then feedback to the address stage.
// Optional WAIT-state timeout enabled by defining RDCH_TIMEOUT_EN.
module axil_rdata_channel #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  addr_valid,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-3:0] mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_err,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  fb_ready,
  output logic [1:0]            fb_resp
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, FB} state_t;
  state_t state;
  logic addr_q;
  logic accept;
  logic in_range;
  assign accept   = state == IDLE && addr_valid && !addr_q;
  assign in_range = 32'(addr_in[ADDR_WIDTH-1:2]) < NUM_REGS;
`ifdef RDCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) < 4 ? 4 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state       <= IDLE;
      addr_q      <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      RVALID      <= 1'b0;
      RDATA       <= '0;
      RRESP       <= 2'b00;
      fb_ready    <= 1'b0;
      fb_resp     <= 2'b00;
`ifdef RDCH_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      addr_q    <= addr_valid;
      mem_rd_en <= 1'b0;
      fb_ready  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          mem_rd_addr <= addr_in[ADDR_WIDTH-1:2];
          if (in_range) begin
            state     <= ISSUE;
            mem_rd_en <= 1'b1;
          end else begin
            state  <= RESP;
            RVALID <= 1'b1;
            RDATA  <= '0;
            RRESP  <= 2'b11;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef RDCH_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        WAIT: begin
          if (mem_rd_valid) begin
            state  <= RESP;
            RVALID <= 1'b1;
            RDATA  <= mem_rd_data;
            RRESP  <= mem_rd_err ? 2'b10 : 2'b00;
          end
`ifdef RDCH_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state  <= RESP;
            RVALID <= 1'b1;
            RDATA  <= '0;
            RRESP  <= 2'b10;
          end
          cnt <= cnt + 1'b1;
`endif
        end
        RESP: if (RREADY) begin
          state    <= FB;
          RVALID   <= 1'b0;
          fb_ready <= 1'b1;
          // 00->00, 10->01, 11->11
          fb_resp  <= {RRESP[0], RRESP[1]};
        end
        FB: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
